// File: rtl/fm_sb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fm_sb_pkg: shared types and constants for the spy-buffer channel
// Revision: 1.0
// ----------------------------------------------------------------------------
package fm_sb_pkg;

  localparam int FM_SB_PB_MODE_WIDTH = 2;

  localparam int unsigned PB_OFF  = 0;
  localparam int unsigned PB_ONCE = 1;
  localparam int unsigned PB_LOOP = 2;

  typedef enum logic [1:0] {
    CAPTURE  = 2'd0,
    FROZEN   = 2'd1,
    PLAYBACK = 2'd2,
    INIT     = 2'd3
  } fm_sb_state_t;

endpackage
`default_nettype wire

// File: rtl/fm_sb_dpram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fm_sb_dpram: simple dual-port RAM, one write port, one registered read port
// Revision: 1.0
// ----------------------------------------------------------------------------
module fm_sb_dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Kept in the plain inferred-BRAM template; a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fm_spy_buffer_ch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fm_spy_buffer_ch: one spy-buffer channel - capture, freeze, playback, readback
// Revision: 1.0
// ----------------------------------------------------------------------------
module fm_spy_buffer_ch
  import fm_sb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int PB_MODE_WIDTH = FM_SB_PB_MODE_WIDTH
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     freeze,
  input  logic [PB_MODE_WIDTH-1:0] playback_mode,
  input  logic                     init_spy_mem,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic [ADDR_WIDTH-1:0]    last_wr_addr,
  output logic                     wrapped,
  output logic                     frozen,
  output logic                     busy_init,
  output logic                     pb_done
);

  localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX  = {ADDR_WIDTH{1'b1}};
  localparam logic [PB_MODE_WIDTH-1:0] MODE_OFF  = PB_MODE_WIDTH'(PB_OFF);
  localparam logic [PB_MODE_WIDTH-1:0] MODE_ONCE = PB_MODE_WIDTH'(PB_ONCE);
  localparam logic [PB_MODE_WIDTH-1:0] MODE_LOOP = PB_MODE_WIDTH'(PB_LOOP);

  fm_sb_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] last_wr_addr_q, last_wr_addr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  pb_done_q, pb_done_d;
  logic [ADDR_WIDTH-1:0] pb_ptr_q, pb_ptr_d;
  logic                  has_data_q, has_data_d;
  logic                  init_prev_q, init_prev_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [DATA_WIDTH-1:0] pass_data_q, pass_data_d;
  logic                  pass_valid_q, pass_valid_d;
  logic                  pb_valid_q, pb_valid_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  init_rise;
  logic                  mode_once;
  logic                  mode_loop;
  logic [ADDR_WIDTH-1:0] oldest;

  assign init_rise = init_spy_mem & ~init_prev_q;
  assign mode_once = (playback_mode == MODE_ONCE);
  assign mode_loop = (playback_mode == MODE_LOOP);
  assign oldest    = wrapped_q ? wr_ptr_q : '0;

  fm_sb_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (axi_clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    last_wr_addr_d = last_wr_addr_q;
    wrapped_d      = wrapped_q;
    pb_done_d      = pb_done_q;
    pb_ptr_d       = pb_ptr_q;
    has_data_d     = has_data_q;
    init_prev_d    = init_spy_mem;
    init_addr_d    = init_addr_q;
    pass_data_d    = '0;
    pass_valid_d   = 1'b0;
    pb_valid_d     = 1'b0;
    rd_valid_d     = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = wr_ptr_q;
    ram_wdata      = in_data;
    ram_re         = 1'b0;
    ram_raddr      = rd_addr;

    // Port B belongs to playback while in PLAYBACK; AXI readback is dropped then.
    if (rd_en && (state_q != PLAYBACK)) begin
      ram_re     = 1'b1;
      ram_raddr  = rd_addr;
      rd_valid_d = 1'b1;
    end

    if ((playback_mode == MODE_OFF) || !freeze) begin
      pb_done_d = 1'b0;
    end

    if (init_rise) begin
      state_d     = INIT;
      init_addr_d = '0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (freeze) begin
            state_d = FROZEN;
          end else begin
            pass_data_d  = in_data;
            pass_valid_d = in_valid;
            if (in_valid) begin
              ram_we         = 1'b1;
              ram_waddr      = wr_ptr_q;
              ram_wdata      = in_data;
              last_wr_addr_d = wr_ptr_q;
              wr_ptr_d       = wr_ptr_q + ADDR_WIDTH'(1);
              has_data_d     = 1'b1;
              if (wr_ptr_q == ADDR_MAX) begin
                wrapped_d = 1'b1;
              end
            end
          end
        end

        FROZEN: begin
          if (!freeze) begin
            state_d = CAPTURE;
          end else if ((mode_once || mode_loop) && !pb_done_q && has_data_q) begin
            state_d  = PLAYBACK;
            pb_ptr_d = oldest;
          end
        end

        PLAYBACK: begin
          if (!freeze) begin
            state_d = CAPTURE;
          end else if (!(mode_once || mode_loop)) begin
            state_d = FROZEN;
          end else begin
            ram_re     = 1'b1;
            ram_raddr  = pb_ptr_q;
            pb_valid_d = 1'b1;
            if (pb_ptr_q == last_wr_addr_q) begin
              if (mode_once) begin
                pb_done_d = 1'b1;
                state_d   = FROZEN;
              end else begin
                pb_ptr_d = oldest;
              end
            end else begin
              pb_ptr_d = pb_ptr_q + ADDR_WIDTH'(1);
            end
          end
        end

        INIT: begin
          ram_we      = 1'b1;
          ram_waddr   = init_addr_q;
          ram_wdata   = '0;
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == ADDR_MAX) begin
            wr_ptr_d       = '0;
            wrapped_d      = 1'b0;
            last_wr_addr_d = '0;
            pb_done_d      = 1'b0;
            has_data_d     = 1'b0;
            state_d        = freeze ? FROZEN : CAPTURE;
          end
        end

        default: begin
          state_d = CAPTURE;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q        <= CAPTURE;
      wr_ptr_q       <= '0;
      last_wr_addr_q <= '0;
      wrapped_q      <= 1'b0;
      pb_done_q      <= 1'b0;
      pb_ptr_q       <= '0;
      has_data_q     <= 1'b0;
      init_prev_q    <= 1'b0;
      init_addr_q    <= '0;
      pass_data_q    <= '0;
      pass_valid_q   <= 1'b0;
      pb_valid_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      last_wr_addr_q <= last_wr_addr_d;
      wrapped_q      <= wrapped_d;
      pb_done_q      <= pb_done_d;
      pb_ptr_q       <= pb_ptr_d;
      has_data_q     <= has_data_d;
      init_prev_q    <= init_prev_d;
      init_addr_q    <= init_addr_d;
      pass_data_q    <= pass_data_d;
      pass_valid_q   <= pass_valid_d;
      pb_valid_q     <= pb_valid_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // RAM output is shared: playback and readback never own it in the same cycle.
  assign out_data     = pb_valid_q ? ram_rdata : pass_data_q;
  assign out_valid    = pb_valid_q | pass_valid_q;
  assign rd_data      = rd_valid_q ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign last_wr_addr = last_wr_addr_q;
  assign wrapped      = wrapped_q;
  assign frozen       = (state_q == FROZEN) || (state_q == PLAYBACK);
  assign busy_init    = (state_q == INIT);
  assign pb_done      = pb_done_q;

endmodule
`default_nettype wire

// File: doc/fm_spy_buffer_ch.md
Name: fm_spy_buffer_ch

Overview:
- One spy-buffer channel; one instance per mapped spy buffer.
- Consumes the per-channel freeze, playback_mode and init_spy_mem controls produced by the spy control block.
- Captures a data stream into a circular memory, stops capture on freeze, and replays the frozen contents onto the output in single-pass or loop mode.
- Gives AXI-side random read access to the captured data and exposes capture status.

Parameters:
- DATA_WIDTH, 32, width of captured and replayed data
- ADDR_WIDTH, 10, memory depth is 2**ADDR_WIDTH words
- PB_MODE_WIDTH, 2, width of playback_mode

Ports:
- axi_clk  in  1  single clock for the whole block
- axi_reset  in  1  synchronous reset, active-high
- freeze  in  1  freeze this channel (already masked upstream)
- playback_mode  in  PB_MODE_WIDTH  0=off, 1=single pass, 2=loop, 3=reserved (treated as off)
- init_spy_mem  in  1  level; its rising edge starts a memory clear
- in_data  in  DATA_WIDTH  stream data
- in_valid  in  1  stream qualifier
- out_data  out  DATA_WIDTH  pass-through or playback data
- out_valid  out  1  output qualifier
- rd_addr  in  ADDR_WIDTH  AXI readback address
- rd_en  in  1  AXI readback strobe
- rd_data  out  DATA_WIDTH  readback data
- rd_valid  out  1  readback data valid
- last_wr_addr  out  ADDR_WIDTH  address of the newest captured word
- wrapped  out  1  capture has wrapped at least once since reset or init
- frozen  out  1  block is in FROZEN or PLAYBACK
- busy_init  out  1  memory clear in progress
- pb_done  out  1  single-pass playback has completed

Behaviour:
- Reset values: all outputs 0; wr_ptr=0; state=CAPTURE. Memory contents are not reset.
- Memory: simple dual-port RAM.
  - Port A writes (capture and init).
  - Port B reads with 1-cycle latency, shared by playback and AXI readback.
- State CAPTURE:
  - Passthrough: out_data/out_valid equal in_data/in_valid, registered with 1-cycle latency.
  - On in_valid: write mem[wr_ptr], last_wr_addr<=wr_ptr, wr_ptr<=wr_ptr+1 (modulo depth).
  - When wr_ptr wraps from max to 0, set wrapped.
  - freeze=1 -> FROZEN. An in_valid word in the same cycle is NOT written.
- State FROZEN:
  - No writes. out_valid=0.
  - freeze=0 -> CAPTURE.
  - freeze=1 with playback_mode in {1,2} and pb_done=0 -> PLAYBACK; pb_ptr<=oldest, where oldest = wrapped ? wr_ptr : 0.
- State PLAYBACK:
  - Issue a read at pb_ptr each cycle. out_data=mem[pb_ptr] with out_valid=1 one cycle later, so the first word appears 2 cycles after entry.
  - After issuing last_wr_addr:
    - Mode 1: set pb_done, go to FROZEN.
    - Mode 2: pb_ptr<=oldest and continue with no bubble.
  - freeze=0 -> CAPTURE next cycle; the in-flight read is discarded and out_valid=0.
  - playback_mode goes to 0 or 3 -> FROZEN; in-flight word discarded.
- pb_done clears when playback_mode=0 or freeze=0.
- Empty buffer: if no word has been captured since reset or init, PLAYBACK is not entered; the block stays in FROZEN.
- State INIT:
  - Entered from any state on the init_spy_mem rising edge. This has highest priority; freeze and playback are ignored.
  - Write 0 to every address, one per cycle (2**ADDR_WIDTH cycles), busy_init=1, out_valid=0.
  - On completion: wr_ptr=0, wrapped=0, last_wr_addr=0, pb_done=0. Then go to FROZEN if freeze=1, else CAPTURE.
  - A second rising edge during INIT restarts the clear from address 0.
- AXI readback:
  - rd_en is served only when state is not PLAYBACK. rd_data/rd_valid appear 1 cycle after rd_en.
  - rd_en during PLAYBACK is dropped; rd_valid stays 0.
  - rd_en during INIT returns current (partially cleared) contents.
- axi_reset mid-operation: immediate return to reset values on the next edge; any in-progress INIT is abandoned.

Decomposition:
- fm_sb_pkg:
  - Add enum fm_sb_state_t {CAPTURE, FROZEN, PLAYBACK, INIT}.
  - Add playback mode constants PB_OFF=0, PB_ONCE=1, PB_LOOP=2.
  - Reuse the existing pb_mode_width constant.
- Sub-module fm_sb_dpram (parameterised simple dual-port RAM, 1-cycle read) so it can be retargeted to BRAM. The FSM and pointers stay in fm_spy_buffer_ch.

Test Plan (ADDR_WIDTH=4, i.e. 16 words):
- Write 5 words 0xA0..0xA4, then freeze=1, mode=1 -> out_valid for exactly 5 cycles with 0xA0..0xA4 starting 2 cycles after entry; then pb_done=1, last_wr_addr=4, wrapped=0.
- Write 20 words 0..19, freeze, mode=2 -> out sequence 4,5,...,19,4,5,... continuous with no gap; wrapped=1, last_wr_addr=3.
- Freeze in the same cycle as in_valid of 0x55 -> 0x55 is not stored; readback of the next address returns the old contents; last_wr_addr unchanged.
- Mid-loop playback, drop freeze -> out_valid=0 from the next cycle; the next in_data 0x77 is captured at the old wr_ptr and passed through after 1 cycle.
- Pulse init_spy_mem during PLAYBACK -> busy_init=1 for 16 cycles, out_valid=0; readback of all 16 addresses returns 0; wrapped=0.
- Issue rd_en with rd_addr=2 during PLAYBACK -> rd_valid=0. Issue the same in FROZEN -> rd_valid=1 one cycle later with the stored word.
